// File: rtl/count_monitor_if.sv
// Observer-side bundle for count_monitor: sampled counter inputs
// plus the lock, event and error outputs.
interface count_monitor_if #(
   parameter int WIDTH   = 4,
   parameter int EPOCH_W = 8
);
   logic [WIDTH-1:0]   count;
   logic [WIDTH-1:0]   match_val;
   logic               clear;
   logic               locked;
   logic               wrap_pulse;
   logic               match_pulse;
   logic [EPOCH_W-1:0] epoch;
   logic [7:0]         err_count;
   logic               err_flag;

   modport master (
      output count, match_val, clear,
      input  locked, wrap_pulse, match_pulse,
      input  epoch, err_count, err_flag
   );

   modport slave (
      input  count, match_val, clear,
      output locked, wrap_pulse, match_pulse,
      output epoch, err_count, err_flag
   );
endinterface

// File: rtl/count_monitor.sv
// Sequence checker for a free-running counter: locks on consecutive
// +1 steps, strobes wrap/match while locked, tallies discontinuities.
module count_monitor #(
   parameter int WIDTH    = 4,
   parameter int EPOCH_W  = 8,
   parameter int SYNC_LEN = 2
) (
   input logic           clk,
   input logic           reset,
   count_monitor_if.slave bus
);
   localparam int RUN_W = $clog2(SYNC_LEN + 1);

   typedef enum logic {UNLOCKED, LOCKED} state_t;

   state_t             state;
   logic [WIDTH-1:0]   prev;
   logic [WIDTH-1:0]   prev_inc;
   logic               prev_valid;
   logic [RUN_W-1:0]   run;
   logic               wrap_q;
   logic               match_q;
   logic [EPOCH_W-1:0] epoch_q;
   logic [7:0]         err_q;
   logic               flag_q;

   logic good;
   logic hold;
   logic live;
   logic wrap_ev;
   logic match_ev;
   logic jump_ev;

   assign prev_inc = prev + 1'b1;
   assign good     = bus.count == prev_inc;
   assign hold     = bus.count == prev;
   assign live     = prev_valid && state == LOCKED;
   assign wrap_ev  = live && good && bus.count == '0;
   assign match_ev = live && good && bus.count == bus.match_val;
   assign jump_ev  = live && !good && !hold;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= UNLOCKED;
         prev       <= '0;
         prev_valid <= 1'b0;
         run        <= '0;
         wrap_q     <= 1'b0;
         match_q    <= 1'b0;
         epoch_q    <= '0;
         err_q      <= '0;
         flag_q     <= 1'b0;
      end else begin
         prev       <= bus.count;
         prev_valid <= 1'b1;
         wrap_q     <= wrap_ev;
         match_q    <= match_ev;
         // the very first sample after reset is a capture only
         if (prev_valid) begin
            unique case (state)
               UNLOCKED: begin
                  if (!good) begin
                     run <= '0;
                  end else if (run == RUN_W'(SYNC_LEN - 1)) begin
                     run   <= RUN_W'(SYNC_LEN);
                     state <= LOCKED;
                  end else begin
                     run <= run + 1'b1;
                  end
               end
               LOCKED: begin
                  if (!good) begin
                     run   <= '0;
                     state <= UNLOCKED;
                  end
               end
               default: state <= UNLOCKED;
            endcase
         end
         if (bus.clear) begin
            epoch_q <= '0;
            err_q   <= '0;
            flag_q  <= 1'b0;
         end else begin
            if (wrap_ev)
               epoch_q <= epoch_q + 1'b1;
            if (jump_ev) begin
               flag_q <= 1'b1;
               if (err_q != 8'hFF)
                  err_q <= err_q + 8'd1;
            end
         end
      end
   end

   assign bus.locked      = state == LOCKED;
   assign bus.wrap_pulse  = wrap_q;
   assign bus.match_pulse = match_q;
   assign bus.epoch       = epoch_q;
   assign bus.err_count   = err_q;
   assign bus.err_flag    = flag_q;
endmodule

// File: tb/tb_count_monitor.sv
// Bench for count_monitor: vector table, scripted corner cases and
// random traffic against a history-based reference model.
module tb_count_monitor;
   logic clk;
   logic reset;
   int   passed;
   int   total;

   count_monitor_if #(.WIDTH(4), .EPOCH_W(8)) mon ();

   count_monitor #(.WIDTH(4), .EPOCH_W(8), .SYNC_LEN(2)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (mon)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference: recent sample history since reset
   int q[$];
   int m_epoch;
   int m_err;
   bit m_flag;
   bit m_wrap;
   bit m_match;
   bit m_locked;

   typedef struct {
      int c;
      int mv;
      bit clr;
      int expv;
   } vec_t;

   vec_t tbl[18];

   function automatic int mk(bit l, bit w, bit m, int e, int er, bit f);
      return int'({l, w, m, 8'(e), 8'(er), f});
   endfunction

   function automatic int dut_vec();
      return int'({mon.locked, mon.wrap_pulse, mon.match_pulse,
                   mon.epoch, mon.err_count, mon.err_flag});
   endfunction

   function automatic int exp_vec();
      return mk(m_locked, m_wrap, m_match, m_epoch, m_err, m_flag);
   endfunction

   // number of consecutive +1 steps at the tail of the history
   function automatic int streak();
      int n = 0;
      for (int i = q.size() - 1; i >= 1; i--) begin
         if (q[i] == (q[i-1] + 1) % 16) n++;
         else break;
      end
      return n;
   endfunction

   task automatic chk(string name, int got, int expv);
      total++;
      if (got === expv) passed++;
      else $display("FAIL %s got=%0h expected=%0h at %0t",
                    name, got, expv, $time);
   endtask

   task automatic model_step(int c, int mv, bit clr);
      bit good = 0;
      bit hold = 0;
      bit was  = 0;
      if (q.size() > 0) begin
         good = c == (q[$] + 1) % 16;
         hold = c == q[$];
         was  = streak() >= 2;
      end
      q.push_back(c);
      if (q.size() > 6) void'(q.pop_front());
      m_locked = streak() >= 2;
      m_wrap   = was && good && c == 0;
      m_match  = was && good && c == mv;
      if (clr) begin
         m_epoch = 0;
         m_err   = 0;
         m_flag  = 0;
      end else begin
         if (m_wrap) m_epoch = (m_epoch + 1) % 256;
         if (was && !good && !hold) begin
            if (m_err < 255) m_err++;
            m_flag = 1;
         end
      end
   endtask

   task automatic step(int c, int mv, bit clr, string name);
      mon.count     = 4'(c);
      mon.match_val = 4'(mv);
      mon.clear     = clr;
      @(posedge clk);
      #1;
      model_step(c, mv, clr);
      chk(name, dut_vec(), exp_vec());
   endtask

   task automatic model_reset();
      q.delete();
      m_epoch  = 0;
      m_err    = 0;
      m_flag   = 0;
      m_wrap   = 0;
      m_match  = 0;
      m_locked = 0;
   endtask

   // assert reset between edges, hold it across one edge
   task automatic do_reset();
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      chk("reset_zero", dut_vec(), 0);
      @(posedge clk);
      #2;
      reset = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int mpc;
      int wpc;
      int last;
      int c;
      int r;

      passed = 0;
      total  = 0;
      reset  = 1'b0;
      mon.count     = '0;
      mon.match_val = '0;
      mon.clear     = 1'b0;
      model_reset();

      tbl[0]  = '{14, 0, 0, mk(0,0,0,0,0,0)};
      tbl[1]  = '{15, 0, 0, mk(0,0,0,0,0,0)};
      tbl[2]  = '{ 0, 0, 0, mk(1,0,0,0,0,0)};
      tbl[3]  = '{ 1, 1, 0, mk(1,0,1,0,0,0)};
      tbl[4]  = '{ 2, 1, 0, mk(1,0,0,0,0,0)};
      tbl[5]  = '{ 2, 2, 0, mk(0,0,0,0,0,0)};
      tbl[6]  = '{ 3, 0, 0, mk(0,0,0,0,0,0)};
      tbl[7]  = '{ 4, 0, 0, mk(1,0,0,0,0,0)};
      tbl[8]  = '{ 5, 5, 0, mk(1,0,1,0,0,0)};
      tbl[9]  = '{ 9, 9, 0, mk(0,0,0,0,1,1)};
      tbl[10] = '{10, 0, 0, mk(0,0,0,0,1,1)};
      tbl[11] = '{11, 0, 0, mk(1,0,0,0,1,1)};
      tbl[12] = '{12, 0, 1, mk(1,0,0,0,0,0)};
      tbl[13] = '{13,13, 0, mk(1,0,1,0,0,0)};
      tbl[14] = '{14, 0, 0, mk(1,0,0,0,0,0)};
      tbl[15] = '{15, 0, 0, mk(1,0,0,0,0,0)};
      tbl[16] = '{ 0, 0, 0, mk(1,1,1,1,0,0)};
      tbl[17] = '{ 1, 0, 1, mk(1,0,0,0,0,0)};

      #1;
      chk("por_zero", dut_vec(), 0);
      @(posedge clk);
      #2;
      reset = 1'b1;

      foreach (tbl[i]) begin
         step(tbl[i].c, tbl[i].mv, tbl[i].clr, "tbl_model");
         chk($sformatf("tbl_%0d", i), dut_vec(), tbl[i].expv);
      end

      // lock, wrap and match over three passes
      do_reset();
      mpc = 0;
      wpc = 0;
      for (int p = 0; p < 3; p++) begin
         for (int v = 0; v < 16; v++) begin
            step(v, 5, 0, "pass");
            if (p == 0 && v == 1) chk("unlocked_at1", mon.locked, 0);
            if (p == 0 && v == 2) chk("locked_at2", mon.locked, 1);
            mpc += int'(mon.match_pulse);
            wpc += int'(mon.wrap_pulse);
         end
      end
      chk("match_cnt", mpc, 3);
      chk("wrap_cnt", wpc, 2);
      chk("epoch_2", mon.epoch, 2);
      chk("err_0", mon.err_count, 0);

      // discontinuity
      for (int v = 0; v < 4; v++) step(v, 5, 0, "pre_jump");
      step(7, 5, 0, "jump");
      chk("jump_err", mon.err_count, 1);
      chk("jump_flag", mon.err_flag, 1);
      chk("jump_unlock", mon.locked, 0);
      step(8, 5, 0, "relock8");
      step(9, 5, 0, "relock9");
      chk("relock", mon.locked, 1);
      chk("flag_sticky", mon.err_flag, 1);

      // upstream hold
      for (int v = 10; v < 16; v++) step(v, 5, 0, "pre_hold");
      step(0, 5, 0, "pre_hold0");
      step(0, 5, 0, "hold1");
      chk("hold_unlock", mon.locked, 0);
      step(0, 5, 0, "hold2");
      step(0, 5, 0, "hold3");
      chk("hold_no_err", mon.err_count, 1);
      step(1, 5, 0, "resume1");
      step(2, 5, 0, "resume2");
      chk("hold_relock", mon.locked, 1);

      // saturation
      for (int i = 0; i < 260; i++) begin
         step(0, 15, 0, "sat");
         step(1, 15, 0, "sat");
         step(2, 15, 0, "sat");
         step(9, 15, 0, "sat");
      end
      chk("sat_255", mon.err_count, 255);
      step(10, 15, 0, "sat_hold");
      chk("sat_stays", mon.err_count, 255);
      step(11, 15, 1, "sat_clear");
      chk("clear_err", mon.err_count, 0);
      chk("clear_flag", mon.err_flag, 0);

      // clear on the same sample as a wrap
      do_reset();
      for (int p = 0; p < 4; p++)
         for (int v = 0; v < 16; v++) step(v, 7, 0, "coll_pass");
      chk("coll_epoch3", mon.epoch, 3);
      step(0, 7, 1, "coll");
      chk("coll_wrap", mon.wrap_pulse, 1);
      chk("coll_epoch0", mon.epoch, 0);

      // async reset while locked
      do_reset();
      for (int p = 0; p < 5; p++)
         for (int v = 0; v < 16; v++) step(v, 3, 0, "ar_pass");
      chk("ar_epoch4", mon.epoch, 4);
      chk("ar_locked", mon.locked, 1);
      do_reset();
      step(7, 0, 0, "ar_s1");
      chk("ar_lock_s1", mon.locked, 0);
      step(8, 0, 0, "ar_s2");
      chk("ar_lock_s2", mon.locked, 0);
      step(9, 0, 0, "ar_s3");
      chk("ar_lock_s3", mon.locked, 1);

      // random traffic
      do_reset();
      last = 0;
      for (int i = 0; i < 3000; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 80)      c = (last + 1) % 16;
         else if (r < 88) c = last;
         else             c = int'($urandom_range(0, 15));
         step(c, int'($urandom_range(0, 15)),
              $urandom_range(0, 49) == 0, "rand");
         last = c;
         if ($urandom_range(0, 499) == 0) do_reset();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
